traffic_phase_sched: RTL and testbench
======================================

# traffic_phase_sched

Phase scheduler for the two-way intersection traffic-light design. It divides the 50 MHz board clock down to a 1 s tick and sequences the six light phases. It maintains the per-phase seconds countdown and honours the `change` pushbutton as a skip-to-yellow request. Its `countdown` output feeds the seven-segment decode stage that drives HEX0/HEX1, and its lamp outputs drive the LEDs.

## Interface
- `TICK_CYC`, 50000000, clk cycles per 1 s tick; must be ≥ 2.
- `G_SEC`, 20, green duration in seconds; legal range 1..31.
- `Y_SEC`, 3, yellow duration in seconds; legal range 1..31.
- `AR_SEC`, 1, all-red clearance duration in seconds; legal range 1..31.
- `PED_SEC`, 5, pedestrian-shortened green remainder; legal range 1..31. Used only with `PED_REQ_EN`.

- `clk`  in  1  50 MHz clock.
- `reset`  in  1  asynchronous, active-low reset.
- `change`  in  1  asynchronous pushbutton, active-high; skip request.
- `ped_req`  in  1  asynchronous pedestrian button, active-high. Present only with `PED_REQ_EN`.
- `phase`  out  3  current phase: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2.
- `countdown`  out  5  seconds remaining in the current phase, range 1..31.
- `ns_lamp`  out  3  {R,Y,G} for north-south; one-hot.
- `ew_lamp`  out  3  {R,Y,G} for east-west; one-hot.
- `tick`  out  1  one-cycle pulse at each 1 s boundary.

## Operation
- Phase order: NS_G → NS_Y → AR1 → EW_G → EW_Y → AR2 → NS_G, wrapping forever. Codes 6 and 7 are unreachable; if either is entered, the next cycle goes to AR2 with `countdown`=AR_SEC.
- Lamps are decoded combinationally from the `phase` register:
  - NS_G: ns=G, ew=R.
  - NS_Y: ns=Y, ew=R.
  - EW_G: ns=R, ew=G.
  - EW_Y: ns=R, ew=Y.
  - AR1 and AR2: both R.
- Tick counter `tcnt` runs 0..TICK_CYC-1 and wraps. `tick`=1 in the cycle where `tcnt`==TICK_CYC-1.
- Countdown on `tick`:
  - If `countdown`>1: decrement by 1.
  - If `countdown`==1: advance phase and load the new phase's duration (G_SEC, Y_SEC or AR_SEC).
- `change` path:
  - Passed through a 2-flop synchronizer, then a rising-edge detector; this adds 3 cycles of latency to the edge pulse.
  - Edge pulse in NS_G or EW_G: the next cycle moves to the matching yellow phase with `countdown`=Y_SEC and `tcnt`=0.
  - Edge pulse in any other phase: dropped, not queued.
- Simultaneous edge pulse and expiry tick in a green phase: result is identical to a skip (yellow, Y_SEC, `tcnt`=0).
- An edge pulse coincident with a non-expiring tick in green: the skip wins and the decrement is discarded.
- Width rules: `countdown` is 5-bit unsigned and never holds 0. `tcnt` width is $clog2(TICK_CYC).

## Timing
- Reset state (asynchronous assert):
  - `phase`=AR2, `countdown`=AR_SEC, `tcnt`=0, `tick`=0.
  - ns_lamp=ew_lamp=3'b100.
  - Synchronizer and edge flops = 0.
- Reset release: first tick occurs TICK_CYC cycles later. A `change` held high through reset release produces no edge pulse.
- Reset asserted mid-phase: all state returns to reset values immediately; no partial phase resumes.
- Phase and countdown update on the clock edge that ends the `tick` cycle. `phase`, `countdown` and the lamps change together, with no intermediate lamp state.
- Skip latency: `change` rising edge → yellow lamp visible 4 clk edges later.
- Nominal cycle length: 2·(G_SEC+Y_SEC+AR_SEC)·TICK_CYC clocks.

## Configuration
- Macro: `TRAFFIC_PED_REQ_EN`.
- Defined:
  - Adds the `ped_req` port with its own 2-flop synchronizer and rising-edge detector.
  - An edge pulse in NS_G or EW_G with `countdown`>PED_SEC sets `countdown`=PED_SEC on the next cycle; `tcnt` is unchanged.
  - An edge pulse elsewhere, or with `countdown`≤PED_SEC, is ignored.
  - If a `change` edge pulse arrives in the same cycle, the `change` skip has priority.
- Undefined: the port and its logic are absent, and behaviour is exactly as described above.

## Test plan
Parameters for all scenarios: TICK_CYC=4, G_SEC=5, Y_SEC=2, AR_SEC=1, PED_SEC=2.
- Reset release, no inputs → phase sequence 5,0,1,2,3,4,5 with countdown loads 1,5,2,1,5,2,1. Each phase lasts countdown·4 cycles; full cycle is 64 clocks.
- In NS_G at countdown=4, pulse `change` high for 2 cycles → phase=1, countdown=2, ns_lamp=010 exactly 4 edges after the rise. The next tick follows 4 cycles later.
- Pulse `change` during NS_Y, AR1 and AR2 → no effect on phase or countdown; the NS_Y duration remains 8 cycles.
- Align a `change` edge pulse with the expiry tick of EW_G (countdown=1) → single transition to EW_Y, countdown=2, no double advance.
- Assert `reset` low for 1 cycle mid-EW_G → phase=5, countdown=1, both lamps 100 immediately, without waiting for a clock edge. The sequence then restarts per scenario 1.
- With `TRAFFIC_PED_REQ_EN`, `ped_req` edge at NS_G countdown=5 → countdown=2 on the next cycle, then yellow after the remaining ticks. An edge at countdown=2 → no change.

Source files
------------

// File: rtl/traffic_phase_sched_if.sv
// traffic_phase_sched_if: button inputs and phase/lamp outputs of the phase scheduler
//   change     button -> scheduler, skip-to-yellow request
//   ped_req    button -> scheduler, pedestrian request (TRAFFIC_PED_REQ_EN only)
//   phase      current phase code 0..5
//   countdown  seconds left in the phase, 1..31
//   ns_lamp    {R,Y,G} north-south, one-hot
//   ew_lamp    {R,Y,G} east-west, one-hot
//   tick       one-cycle 1 s pulse
//   master drives the buttons, slave is the scheduler
interface traffic_phase_sched_if;
   logic       change;
`ifdef TRAFFIC_PED_REQ_EN
   logic       ped_req;
`endif
   logic [2:0] phase;
   logic [4:0] countdown;
   logic [2:0] ns_lamp;
   logic [2:0] ew_lamp;
   logic       tick;
`ifdef TRAFFIC_PED_REQ_EN
   modport master (output change, ped_req, input phase, countdown, ns_lamp, ew_lamp, tick);
   modport slave  (input change, ped_req, output phase, countdown, ns_lamp, ew_lamp, tick);
`else
   modport master (output change, input phase, countdown, ns_lamp, ew_lamp, tick);
   modport slave  (input change, output phase, countdown, ns_lamp, ew_lamp, tick);
`endif
endinterface

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: 1 s tick divider and six-phase intersection light sequencer
//   clk    board clock
//   reset  asynchronous active-low reset
//   tl     traffic_phase_sched_if.slave: change/ped_req in; phase, countdown, lamps, tick out
//   Optional macro TRAFFIC_PED_REQ_EN adds the pedestrian shorten-green request.
module traffic_btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);
   logic s1, s2, s3, vld, arm;
   // arm only after a genuine low sample, so a button held through reset release gives no pulse
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         {s1, s2, s3, vld, arm, pulse} <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         s3    <= s2;
         vld   <= 1'b1;
         arm   <= arm | (vld & ~s1);
         pulse <= arm & s2 & ~s3;
      end
endmodule

module traffic_phase_sched #(
   parameter int TICK_CYC = 50000000,
   parameter int G_SEC    = 20,
   parameter int Y_SEC    = 3,
   parameter int AR_SEC   = 1,
   parameter int PED_SEC  = 5
) (
   input logic                  clk,
   input logic                  reset,
   traffic_phase_sched_if.slave tl
);
   localparam int TW = $clog2(TICK_CYC);
   localparam logic [TW-1:0] TMAX = TW'(TICK_CYC - 1);
   localparam logic [2:0] NS_G = 3'd0, NS_Y = 3'd1, AR1 = 3'd2, EW_G = 3'd3, EW_Y = 3'd4, AR2 = 3'd5;
   logic [TW-1:0] tcnt;
   logic [2:0]    nph;
   logic [4:0]    ndur;
   logic          chg, green, skip;
   traffic_btn_edge u_chg (.clk(clk), .reset(reset), .btn(tl.change), .pulse(chg));
`ifdef TRAFFIC_PED_REQ_EN
   logic ped;
   traffic_btn_edge u_ped (.clk(clk), .reset(reset), .btn(tl.ped_req), .pulse(ped));
`endif
   always_comb begin
      green      = (tl.phase == NS_G) || (tl.phase == EW_G);
      skip       = chg && green;
      nph        = (tl.phase == AR2) ? NS_G : tl.phase + 3'd1;
      ndur       = (nph == NS_G || nph == EW_G) ? 5'(G_SEC) :
                   (nph == NS_Y || nph == EW_Y) ? 5'(Y_SEC) : 5'(AR_SEC);
      tl.tick    = (tcnt == TMAX);
      tl.ns_lamp = (tl.phase == NS_G) ? 3'b001 : (tl.phase == NS_Y) ? 3'b010 : 3'b100;
      tl.ew_lamp = (tl.phase == EW_G) ? 3'b001 : (tl.phase == EW_Y) ? 3'b010 : 3'b100;
   end
   // a skip restarts the second so the yellow gets its full Y_SEC
   always_ff @(posedge clk or negedge reset)
      if (!reset) tcnt <= '0;
      else        tcnt <= (skip || tl.tick) ? '0 : tcnt + TW'(1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tl.phase     <= AR2;
         tl.countdown <= 5'(AR_SEC);
      end else if (tl.phase > AR2) begin
         tl.phase     <= AR2;
         tl.countdown <= 5'(AR_SEC);
      end else if (skip) begin
         tl.phase     <= tl.phase + 3'd1;
         tl.countdown <= 5'(Y_SEC);
      end
`ifdef TRAFFIC_PED_REQ_EN
      else if (ped && green && tl.countdown > 5'(PED_SEC)) begin
         tl.countdown <= 5'(PED_SEC);
      end
`endif
      else if (tl.tick) begin
         tl.phase     <= (tl.countdown == 5'd1) ? nph : tl.phase;
         tl.countdown <= (tl.countdown == 5'd1) ? ndur : tl.countdown - 5'd1;
      end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: scoreboard bench for traffic_phase_sched phase transitions and timing
module tb_traffic_phase_sched;
   localparam int TC = 4, G = 5, Y = 2, AR = 1, PS = 2;
   typedef struct {int ph; int cd; int at;} exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   ne = 0;
   int   npass = 0;
   int   nchk = 0;
   int   last = 5;
   exp_t sb[$];
   exp_t e;
   traffic_phase_sched_if tl();
   traffic_phase_sched #(.TICK_CYC(TC), .G_SEC(G), .Y_SEC(Y), .AR_SEC(AR), .PED_SEC(PS)) dut (
      .clk(clk), .reset(reset), .tl(tl.slave)
   );
   always #5 clk = ~clk;
   always @(posedge clk) ne <= reset ? ne + 1 : 0;
   function automatic int ns_exp(input int ph);
      return (ph == 0) ? 1 : (ph == 1) ? 2 : 4;
   endfunction
   function automatic int ew_exp(input int ph);
      return (ph == 3) ? 1 : (ph == 4) ? 2 : 4;
   endfunction
   task automatic chk(input string tag, input int got, input int exp);
      nchk++;
      if (got == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ne);
   endtask
   task automatic push(input int ph, input int cd, input int at);
      sb.push_back('{ph, cd, at});
   endtask
   task automatic wait_ne(input int n);
      int k = 0;
      while (ne != n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (ne != n) chk("timeout", ne, n);
   endtask
   task automatic press(input int at, input int len);
      wait_ne(at);
      #1 tl.change = 1'b1;
      wait_ne(at + len);
      #1 tl.change = 1'b0;
   endtask
`ifdef TRAFFIC_PED_REQ_EN
   task automatic press_ped(input int at);
      wait_ne(at);
      #1 tl.ped_req = 1'b1;
      wait_ne(at + 2);
      #1 tl.ped_req = 1'b0;
   endtask
`endif
   always @(negedge clk) begin
      if (!reset) last = tl.phase;
      else if (tl.phase != last) begin
         last = tl.phase;
         if (sb.size() == 0) chk("sb_extra", tl.phase, -1);
         else begin
            e = sb.pop_front();
            chk("ph", tl.phase, e.ph);
            chk("cd", tl.countdown, e.cd);
            chk("at", ne, e.at);
            chk("ns", tl.ns_lamp, ns_exp(e.ph));
            chk("ew", tl.ew_lamp, ew_exp(e.ph));
         end
      end
   end
   initial begin
      tl.change = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
      tl.ped_req = 1'b0;
`endif
      #1 reset = 1'b0;
      #1;
      chk("rst_ph", tl.phase, 5);
      chk("rst_cd", tl.countdown, AR);
      chk("rst_ns", tl.ns_lamp, 4);
      chk("rst_ew", tl.ew_lamp, 4);
      chk("rst_tick", tl.tick, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      push(0, 5, 4);   push(1, 2, 24);  push(2, 1, 32);  push(3, 5, 36);
      push(4, 2, 56);  push(5, 1, 64);  push(0, 5, 68);
      push(1, 2, 77);  push(2, 1, 85);  push(3, 5, 89);  push(4, 2, 109);
      push(5, 1, 117); push(0, 5, 121); push(1, 2, 141); push(2, 1, 149);
      push(3, 5, 153); push(4, 2, 173); push(5, 1, 181); push(0, 5, 185);
      push(1, 2, 205); push(2, 1, 213); push(3, 5, 217);
      wait_ne(2);   chk("tick_lo", tl.tick, 0);
      wait_ne(3);   chk("tick_hi", tl.tick, 1);
      wait_ne(72);  chk("cd_pre_skip", tl.countdown, 4);
      press(73, 2);
      wait_ne(80);  chk("cd_skip_hold", tl.countdown, 2);
      chk("tick_after_skip", tl.tick, 1);
      wait_ne(81);  chk("cd_skip_dec", tl.countdown, 1);
      press(116, 2);
      press(142, 2);
      press(148, 2);
      wait_ne(169); chk("cd_ew_last", tl.countdown, 1);
      press(169, 2);
      wait_ne(176); chk("cd_ewy", tl.countdown, 2);
      wait_ne(177); chk("cd_ewy_dec", tl.countdown, 1);
      wait_ne(225);
      chk("sb_drained", sb.size(), 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ph", tl.phase, 5);
      chk("mid_rst_cd", tl.countdown, AR);
      chk("mid_rst_ns", tl.ns_lamp, 4);
      chk("mid_rst_ew", tl.ew_lamp, 4);
      @(negedge clk);
      #2 reset = 1'b1;
      push(0, 5, 4);
`ifdef TRAFFIC_PED_REQ_EN
      push(1, 2, 12); push(2, 1, 20); push(3, 5, 24); push(4, 2, 44);
      press_ped(3);
      wait_ne(6);   chk("ped_cd_pre", tl.countdown, 5);
      wait_ne(7);   chk("ped_cd_short", tl.countdown, 2);
      wait_ne(8);   chk("ped_cd_dec", tl.countdown, 1);
      press_ped(35);
      wait_ne(39);  chk("ped_cd_ignored", tl.countdown, 2);
      wait_ne(40);  chk("ped_cd_dec2", tl.countdown, 1);
`else
      push(1, 2, 24); push(2, 1, 32); push(3, 5, 36); push(4, 2, 56);
      wait_ne(6);   chk("restart_cd", tl.countdown, 5);
`endif
      wait_ne(60);
      chk("sb_final", sb.size(), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
